// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding and framing constants.
// The transmitter uses the same framing constants.
package uart_pkg;

   localparam int UART_DATA_BITS       = 8;
   localparam int UART_OVERSAMPLE      = 16;
   localparam int UART_MID_SAMPLE      = 7;
   localparam int UART_TICK_DIV_115200 = 27;

   // One-hot receiver states
   typedef enum logic [4:0] {
      RX_IDLE      = 5'b00001,
      RX_START     = 5'b00010,
      RX_DATA      = 5'b00100,
      RX_STOP      = 5'b01000,
      RX_WAIT_HIGH = 5'b10000
   } rx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: a one-clk pulse every DIV board clocks.
// The transmitter can use it in place of a divided clock.
module uart_baud_tick #(
   parameter int DIV = 27
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam logic [7:0] LP_LAST = 8'(DIV - 1);

   logic [7:0] r_cnt;
   logic       w_wrap;

   assign w_wrap = (r_cnt == LP_LAST);
   assign tick   = w_wrap;

   // Free-running divider 0..DIV-1, wrapping on the tick cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_wrap) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling and mid-bit sampling.
// Received bytes are held in a valid/ack register with overrun and
// framing-error reporting.
module uart_rx
   import uart_pkg::*;
#(
   parameter int TICK_DIV   = UART_TICK_DIV_115200,
   parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ack,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam logic [3:0] LP_MID_SAMPLE  = 4'(UART_MID_SAMPLE);
   localparam logic [3:0] LP_LAST_SAMPLE = 4'(OVERSAMPLE - 1);
   localparam logic [3:0] LP_LAST_BIT    = 4'(UART_DATA_BITS - 1);

   logic [1:0] r_sync;
   logic       w_rxd_s;
   logic       w_tick;
   rx_state_t  r_state;
   rx_state_t  w_state_nxt;
   logic [3:0] r_sample;
   logic [3:0] w_sample_nxt;
   logic [3:0] r_bit;
   logic [3:0] w_bit_nxt;
   logic [7:0] r_shift;
   logic       w_shift_en;
   logic       w_deliver;
   logic       w_bad_stop;
   logic [7:0] r_data;
   logic       r_valid;
   logic       r_frame_err;
   logic       r_overrun;

   uart_baud_tick #(.DIV(TICK_DIV)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (w_tick)
   );

   assign w_rxd_s = r_sync[1];

   // Two-flop synchroniser for the asynchronous serial input (idles high)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= 2'b11;
      end else begin
         // NOTE: non-blocking so the second flop takes the first flop's old value.
         r_sync <= {r_sync[0], rxd};
      end
   end

   // State, counters and shift register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= RX_IDLE;
         r_sample <= '0;
         r_bit    <= '0;
         r_shift  <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_sample <= w_sample_nxt;
         r_bit    <= w_bit_nxt;
         if (w_shift_en) begin
            r_shift <= {w_rxd_s, r_shift[7:1]};
         end
      end
   end

   // Next-state, counter updates and strobes; everything advances on tick only
   always_comb begin
      // NOTE: every output gets a default first, so no path can infer a latch.
      w_state_nxt  = r_state;
      w_sample_nxt = r_sample;
      w_bit_nxt    = r_bit;
      w_shift_en   = 1'b0;
      w_deliver    = 1'b0;
      w_bad_stop   = 1'b0;
      if (w_tick) begin
         case (r_state)
            RX_IDLE: begin
               if (!w_rxd_s) begin
                  w_state_nxt  = RX_START;
                  w_sample_nxt = '0;
               end
            end
            RX_START: begin
               if (r_sample == LP_MID_SAMPLE) begin
                  if (!w_rxd_s) begin
                     w_state_nxt  = RX_DATA;
                     w_sample_nxt = '0;
                     w_bit_nxt    = '0;
                  end else begin
                     w_state_nxt  = RX_IDLE;
                  end
               end else begin
                  w_sample_nxt = r_sample + 4'd1;
               end
            end
            RX_DATA: begin
               if (r_sample == LP_LAST_SAMPLE) begin
                  w_shift_en   = 1'b1;
                  w_bit_nxt    = r_bit + 4'd1;
                  w_sample_nxt = '0;
                  if (r_bit == LP_LAST_BIT) begin
                     w_state_nxt = RX_STOP;
                  end
               end else begin
                  w_sample_nxt = r_sample + 4'd1;
               end
            end
            RX_STOP: begin
               if (r_sample == LP_LAST_SAMPLE) begin
                  if (w_rxd_s) begin
                     w_deliver   = 1'b1;
                     w_state_nxt = RX_IDLE;
                  end else begin
                     w_bad_stop  = 1'b1;
                     w_state_nxt = RX_WAIT_HIGH;
                  end
               end else begin
                  w_sample_nxt = r_sample + 4'd1;
               end
            end
            RX_WAIT_HIGH: begin
               if (w_rxd_s) begin
                  w_state_nxt = RX_IDLE;
               end
            end
            default: begin
               w_state_nxt = RX_IDLE;
            end
         endcase
      end
   end

   // Holding register: deliver, drop on overrun, or consume on ack
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_frame_err <= w_bad_stop;
         if (w_deliver) begin
            if (!r_valid || rx_ack) begin
               r_data    <= r_shift;
               r_valid   <= 1'b1;
               r_overrun <= r_overrun && !rx_ack;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (r_valid && rx_ack) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
         end
      end
   end

   assign rx_data   = r_data;
   assign rx_valid  = r_valid;
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;
   assign busy      = (r_state != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at TICK_DIV=4 (one bit = 64 clk).
// Expected bytes are queued when a frame is driven and popped when the
// receiver presents rx_valid.
module tb_uart_rx;

   localparam int TICK_DIV = 4;
   localparam int BIT_CLKS = 64;

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b0;
   logic       rxd    = 1'b1;
   logic       rx_ack = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int         checks    = 0;
   int         failures  = 0;
   int         cyc       = 0;
   int         rst_cyc   = 0;
   int         fe_cnt    = 0;
   int         rise_cyc  = 0;
   logic       prev_valid = 1'b0;
   logic [7:0] exp_q[$];

   uart_rx #(.TICK_DIV(TICK_DIV)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rxd       (rxd),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ack    (rx_ack),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   // Count frame_err pulses and note the cycle rx_valid rises
   always @(negedge clk) begin
      if (frame_err) fe_cnt = fe_cnt + 1;
      if (rx_valid && !prev_valid) rise_cyc = cyc;
      prev_valid = rx_valid;
   end

   initial begin
      #800_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Align frame starts to the tick phase established at reset release
   task automatic align4();
      while (((cyc - rst_cyc) % TICK_DIV) != 0) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_lvl, input int stop_clks);
      rxd = 1'b0;
      wait_clks(BIT_CLKS);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         wait_clks(BIT_CLKS);
      end
      rxd = stop_lvl;
      wait_clks(stop_clks);
      rxd = 1'b1;
   endtask

   task automatic ack_pulse();
      rx_ack = 1'b1;
      @(negedge clk);
      rx_ack = 1'b0;
   endtask

   // Wait (bounded) for rx_valid, then pop the scoreboard and compare rx_data
   task automatic expect_byte(input string name);
      int         n;
      logic [7:0] exp;
      n = 0;
      while (!rx_valid && n < 1000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (rx_valid !== 1'b1) begin
         failures++;
         $display("FAIL %s_valid: rx_valid=%b required 1 (timeout)", name, rx_valid);
      end
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL %s_data: rx_data=%h but no byte was expected", name, rx_data);
      end else begin
         exp = exp_q.pop_front();
         if (rx_data !== exp) begin
            failures++;
            $display("FAIL %s_data: rx_data=%h required %h", name, rx_data, exp);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      wait_clks(3);
      checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h want 00", rx_data); end
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
      checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b want 0", overrun); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
      rst_n   = 1'b1;
      rst_cyc = cyc;
      wait_clks(20);
   endtask

   task automatic test_basic();
      logic [7:0] pat[2];
      int         fe0;
      pat[0] = 8'h55;
      pat[1] = 8'hA5;
      fe0 = fe_cnt;
      for (int k = 0; k < 2; k++) begin
         align4();
         exp_q.push_back(pat[k]);
         send_frame(pat[k], 1'b1, BIT_CLKS);
         expect_byte("basic");
         checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL basic_overrun: got %b want 0", overrun); end
         wait_clks(10);
         ack_pulse();
         checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL basic_ack_clears: rx_valid=%b want 0", rx_valid); end
      end
      checks++; if (fe_cnt != fe0) begin failures++; $display("FAIL basic_frame_err: pulses=%0d want 0", fe_cnt - fe0); end
   endtask

   task automatic test_glitch();
      int fe0;
      fe0 = fe_cnt;
      align4();
      rxd = 1'b0;
      wait_clks(20);
      rxd = 1'b1;
      wait_clks(100);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_idle: busy=%b want 0", busy); end
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL glitch_valid: rx_valid=%b want 0", rx_valid); end
      checks++; if (fe_cnt != fe0) begin failures++; $display("FAIL glitch_frame_err: pulses=%0d want 0", fe_cnt - fe0); end
   endtask

   task automatic test_framing();
      int fe0;
      fe0 = fe_cnt;
      align4();
      send_frame(8'h3C, 1'b0, 3 * BIT_CLKS);
      rxd = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL break_busy: busy=%b want 1", busy); end
      rxd = 1'b1;
      wait_clks(10);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL break_release: busy=%b want 0", busy); end
      checks++; if (fe_cnt != fe0 + 1) begin failures++; $display("FAIL framing_pulses: pulses=%0d want 1", fe_cnt - fe0); end
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL framing_valid: rx_valid=%b want 0", rx_valid); end
      wait_clks(BIT_CLKS);
      align4();
      exp_q.push_back(8'h41);
      send_frame(8'h41, 1'b1, BIT_CLKS);
      expect_byte("after_break");
      ack_pulse();
   endtask

   task automatic test_overrun();
      align4();
      exp_q.push_back(8'h31);
      send_frame(8'h31, 1'b1, BIT_CLKS);
      send_frame(8'h32, 1'b1, BIT_CLKS);
      expect_byte("overrun_keep");
      checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_set: overrun=%b want 1", overrun); end
      ack_pulse();
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_clear: overrun=%b want 0", overrun); end
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL overrun_valid: rx_valid=%b want 0", rx_valid); end
   endtask

   // Delivery with rx_ack in the same cycle: the ack timing is taken from the
   // first frame's rx_valid rise, the second frame starts at the same tick phase
   task automatic test_back_to_back();
      int s1;
      int s2;
      int d;
      align4();
      s1 = cyc;
      exp_q.push_back(8'h31);
      send_frame(8'h31, 1'b1, BIT_CLKS);
      expect_byte("b2b_first");
      d = rise_cyc - s1;
      checks++; if (d < 580 || d > 650) begin failures++; $display("FAIL b2b_latency: rise offset=%0d want 580..650", d); end
      align4();
      s2 = cyc;
      exp_q.push_back(8'h32);
      fork
         send_frame(8'h32, 1'b1, BIT_CLKS);
         begin
            while (cyc < s2 + d - 1 && cyc < s2 + 700) @(negedge clk);
            ack_pulse();
         end
      join
      expect_byte("b2b_second");
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun: overrun=%b want 0", overrun); end
   endtask

   // rx_valid is still high from the previous test, so reset visibly clears it
   task automatic test_reset_midframe();
      int s;
      align4();
      s = cyc;
      fork
         send_frame(8'h7E, 1'b1, BIT_CLKS);
         begin
            while (cyc < s + 5 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
            rst_n = 1'b0;
            #1;
            checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL midrst_data: got %h want 00", rx_data); end
            checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %b want 0", rx_valid); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b want 0", busy); end
            checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL midrst_overrun: got %b want 0", overrun); end
            checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL midrst_frame_err: got %b want 0", frame_err); end
         end
      join
      wait_clks(5);
      rst_n   = 1'b1;
      rst_cyc = cyc;
      wait_clks(20);
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL midrst_no_partial: rx_valid=%b want 0", rx_valid); end
      align4();
      exp_q.push_back(8'h20);
      send_frame(8'h20, 1'b1, BIT_CLKS);
      expect_byte("after_reset");
      ack_pulse();
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic();
      test_glitch();
      test_framing();
      test_overrun();
      test_back_to_back();
      test_reset_midframe();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_empty: %0d bytes never delivered", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver for the serial port: deserialises RXD into bytes with 16x oversampling and mid-bit sampling.
- Complements the existing TXD path on the same 50 MHz board clock. Default rate is ~115200 baud.
- Received bytes go to user logic through a level-valid/ack holding register, with framing-error and overrun reporting.

Parameters:
- TICK_DIV, 27, board clocks per oversample tick (50 MHz / (115200*16) ≈ 27); legal range 2..255.
- OVERSAMPLE, 16, ticks per bit; fixed at 16, power of two.

Ports:
- clk  in  1  board clock; sole clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- rxd  in  1  serial input, asynchronous to clk; idles high.
- rx_data  out  8  last accepted byte.
- rx_valid  out  1  high while rx_data holds an unacknowledged byte.
- rx_ack  in  1  single-cycle consume strobe; ignored when rx_valid=0.
- frame_err  out  1  one-cycle pulse on a bad stop bit.
- overrun  out  1  sticky; a byte was dropped because rx_valid was still set.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (rst_n low, asynchronous):
  - Outputs: rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - Internal: FSM=IDLE, synchroniser flops=1, tick counter=0, sample counter=0, bit counter=0, shift register=0.
- Reset mid-frame aborts the frame. No partial byte is ever delivered.
- Synchroniser: rxd passes through 2 flops to give rxd_s. All decisions use rxd_s, so input latency is 2 clk.
- Tick generator:
  - Free-running counter 0..TICK_DIV-1.
  - tick=1 for one clk when the counter equals TICK_DIV-1, then the counter wraps to 0.
  - All FSM transitions happen only on tick cycles.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: on tick with rxd_s=0, go to START and clear the sample counter.
  - START: count ticks. At sample count 7 (mid start bit):
    - rxd_s=0: go to DATA, clear the sample counter and bit counter.
    - rxd_s=1: glitch; return to IDLE, nothing reported.
  - DATA: at sample count 15 (one bit period after the previous mid-bit):
    - Shift rxd_s into the MSB of the shift register (LSB-first reception) and increment the bit counter.
    - After the 8th bit, go to STOP with the sample counter cleared.
  - STOP: at sample count 15 (mid stop bit), sample rxd_s:
    - 1: deliver the byte (below), then go to IDLE.
    - 0: pulse frame_err for 1 clk, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until a tick with rxd_s=1, then go to IDLE. This stops a break condition from producing back-to-back false frames.
- Delivery happens in the clk cycle of the stop-bit sample:
  - rx_valid=0: load rx_data, set rx_valid.
  - rx_valid=1 and rx_ack=1 in the same cycle: load the new byte, rx_valid stays 1, no overrun.
  - rx_valid=1 and rx_ack=0: keep the old rx_data, drop the new byte, set overrun.
- rx_ack with no simultaneous delivery: clears rx_valid next cycle and clears overrun.
- Delivery latency: rx_valid rises 1 clk after the mid-stop-bit tick.
- Counters wrap naturally. The sample counter is 4 bits and the bit counter is 4 bits, reaching at most 8.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encoding: one-hot 5-bit, RX_IDLE..RX_WAIT_HIGH.
  - Constants UART_DATA_BITS=8, UART_OVERSAMPLE=16, UART_MID_SAMPLE=7, UART_TICK_DIV_115200=27.
  - These constants are shared with the transmitter.
- One sub-module: uart_baud_tick.
  - Parameter DIV; ports clk, rst_n, tick.
  - Reusable by the transmitter in place of its divided clock.

Test Plan (TICK_DIV=4, so one bit = 64 clk; driver holds each bit 64 clk):
- Send 0x55, then 0xA5, each with a valid stop bit, acking 10 clk after rx_valid. Required: rx_data=0x55 then 0xA5, frame_err=0, overrun=0.
- Pull rxd low for 20 clk (5 ticks), then high. Required: FSM returns to IDLE, rx_valid stays 0, no frame_err.
- Send 0x3C with stop bit held 0 for 3 bit times. Required: one frame_err pulse, rx_valid=0, busy stays high until rxd returns high. A following 0x41 is then received correctly.
- Send 0x31 and 0x32 back-to-back with no ack. Required: rx_data=0x31, overrun=1. Ack, then overrun=0 and rx_valid=0.
- Send 0x31, then 0x32 with rx_ack asserted exactly in the 0x32 delivery cycle. Required: rx_data=0x32, rx_valid=1, overrun=0.
- Assert rst_n=0 mid data bit 4 of 0x7E, release, then send 0x20. Required: all outputs return to reset values immediately, no byte from the aborted frame, and 0x20 is received correctly.
